// File: rtl/trigger_capture_v1_0_pkg.sv
// Shared types for the trigger capture block: FSM encoding and threshold saturation.
package trigger_capture_v1_0_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_WAIT_TRIG,
        ST_POST,
        ST_DONE
    } state_t;

    // Clamp threshold +/- hysteresis into 15-bit signed instead of wrapping.
    function automatic logic signed [14:0] sat15(input logic signed [15:0] v);
        if (v > 16'sd16383)
            return 15'h3fff;
        else if (v < -16'sd16384)
            return 15'h4000;
        else
            return v[14:0];
    endfunction

endpackage

// File: rtl/capture_ram_v1_0.sv
// Simple dual-port capture buffer: one write port, one registered read port.
module capture_ram_v1_0 #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk)
        if (we)
            mem[wr_addr] <= wr_data;

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk or negedge rstn)
        if (!rstn)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];

endmodule

// File: rtl/trigger_capture_v1_0.sv
// Pre/post-trigger sample capture with prescaled strobe and hysteresis-qualified edge trigger.
module trigger_capture_v1_0
    import trigger_capture_v1_0_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [31:0]         i32_prescaler,
    input  logic signed [13:0]  is14_data,
    input  logic signed [13:0]  is14_threshold,
    input  logic [13:0]         i14_hysteresis,
    input  logic                i_edge,
    input  logic                i_arm,
    input  logic [ADDR_W-1:0]   i_pretrig,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output logic signed [13:0]  os14_rd_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_trigger
);

    state_t             state, state_nx;
    logic [31:0]        pre_cnt;
    logic               strobe, arm_ok, fire, we;
    logic               qual, qual_set, hit, edge_q, edge_chg;
    logic [ADDR_W-1:0]  wr_ptr, start_ptr, rd_ptr, fill_cnt, fill_inc, fill_len, pretrig_q;
    logic signed [15:0] thr16, hys16;
    logic signed [14:0] thr15, thr_lo, thr_hi, data15;
    logic [13:0]        rd_raw;

    assign strobe = pre_cnt >= i32_prescaler;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn)
            pre_cnt <= '0;
        else if (strobe)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 32'd1;

    assign thr16    = {{2{is14_threshold[13]}}, is14_threshold};
    assign hys16    = {2'b00, i14_hysteresis};
    assign thr15    = thr16[14:0];
    assign thr_lo   = sat15(thr16 - hys16);
    assign thr_hi   = sat15(thr16 + hys16);
    assign data15   = {is14_data[13], is14_data};
    assign qual_set = i_edge ? (data15 >= thr_hi) : (data15 <= thr_lo);
    assign hit      = i_edge ? (data15 <= thr15)  : (data15 >= thr15);
    assign edge_chg = i_edge ^ edge_q;

    assign arm_ok   = i_arm && (state == ST_IDLE || state == ST_DONE);
    // A stale qualifier from the previous edge polarity must not fire.
    assign fire     = (state == ST_WAIT_TRIG) && strobe && qual && !edge_chg && hit;
    assign we       = strobe && (state == ST_PREFILL || state == ST_WAIT_TRIG || state == ST_POST);
    assign fill_len = (state == ST_POST) ? ~pretrig_q : pretrig_q;
    assign fill_inc = fill_cnt + ADDR_W'(1);

    always_ff @(posedge clk or negedge rstn)
        if (!rstn)
            state <= ST_IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE:
                if (i_arm)
                    state_nx = (i_pretrig == '0) ? ST_WAIT_TRIG : ST_PREFILL;
            ST_PREFILL:
                if (strobe && fill_inc == fill_len)
                    state_nx = ST_WAIT_TRIG;
            ST_WAIT_TRIG:
                if (fire)
                    state_nx = (&pretrig_q) ? ST_DONE : ST_POST;
            ST_POST:
                if (strobe && fill_inc == fill_len)
                    state_nx = ST_DONE;
            default:
                state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy    = !(state == ST_IDLE || state == ST_DONE);
        o_done    = (state == ST_DONE);
        o_trigger = fire;
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            wr_ptr    <= '0;
            start_ptr <= '0;
            fill_cnt  <= '0;
            pretrig_q <= '0;
            qual      <= 1'b0;
            edge_q    <= 1'b0;
        end else begin
            edge_q <= i_edge;
            if (arm_ok) begin
                pretrig_q <= i_pretrig;
                wr_ptr    <= '0;
                fill_cnt  <= '0;
                qual      <= 1'b0;
            end else begin
                if (we)
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                if (we && state != ST_WAIT_TRIG)
                    fill_cnt <= fill_inc;
                if (fire) begin
                    start_ptr <= wr_ptr - pretrig_q;
                    fill_cnt  <= '0;
                end
                if (state == ST_WAIT_TRIG) begin
                    if (edge_chg)
                        qual <= 1'b0;
                    else if (strobe && qual_set)
                        qual <= 1'b1;
                end
            end
        end

    assign rd_ptr       = start_ptr + i_rd_addr;
    assign os14_rd_data = rd_raw;

    capture_ram_v1_0 #(
        .ADDR_W (ADDR_W),
        .DATA_W (14)
    ) u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .we      (we),
        .wr_addr (wr_ptr),
        .wr_data (is14_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_raw)
    );

endmodule

// File: tb/tb_trigger_capture_v1_0.sv
// Self-checking bench: sample-level reference model derives trigger point, busy/done timing and buffer contents.
module tb_trigger_capture_v1_0;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic [31:0]        i32_prescaler = '0;
    logic signed [13:0] is14_data = '0;
    logic signed [13:0] is14_threshold = '0;
    logic [13:0]        i14_hysteresis = '0;
    logic               i_edge = 1'b0;
    logic               i_arm = 1'b0;
    logic [ADDR_W-1:0]  i_pretrig = '0;
    logic [ADDR_W-1:0]  i_rd_addr = '0;
    logic signed [13:0] os14_rd_data;
    logic               o_busy, o_done, o_trigger;

    int checks = 0, failures = 0;
    int gcyc = 0, cur_p = 0, last_trig = -1;
    int smp[$];

    trigger_capture_v1_0 #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .i32_prescaler  (i32_prescaler),
        .is14_data      (is14_data),
        .is14_threshold (is14_threshold),
        .i14_hysteresis (i14_hysteresis),
        .i_edge         (i_edge),
        .i_arm          (i_arm),
        .i_pretrig      (i_pretrig),
        .i_rd_addr      (i_rd_addr),
        .os14_rd_data   (os14_rd_data),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_trigger      (o_trigger)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        gcyc++;
        #1;
    endtask

    task automatic do_reset(input int p);
        i_arm = 1'b0;
        i32_prescaler = p;
        cur_p = p;
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_trig", o_trigger, 0);
        chk("rst_rd", os14_rd_data, 0);
        tick();
        rstn = 1'b1;
        gcyc = 0;
    endtask

    task automatic idle_chk(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("idle_busy", o_busy, 0);
            chk("idle_done", o_done, 0);
            chk("idle_trig", o_trigger, 0);
            tick();
        end
    endtask

    task automatic rd_chk(input string tag, input int addr, input int exp);
        i_rd_addr = ADDR_W'(addr);
        tick();
        @(negedge clk);
        chk(tag, os14_rd_data, exp);
        tick();
    endtask

    // Sample sequence per strobe after arm (mode 0 ramp, 1 dither, 2 sine, else random around thr).
    task automatic gen(input int mode, input int n, input int base, input int thr);
        smp.delete();
        for (int j = 0; j < n; j++) begin
            int v;
            case (mode)
                0:       v = base + 10 * j;
                1:       v = (j < base) ? ((j % 2 == 1) ? 1010 : 990) : ((j == base) ? 940 : 1010);
                2:       v = $rtoi(2000.0 * $sin(6.283185307179586 * j / 64.0));
                default: v = thr + int'($urandom_range(3000)) - 1500;
            endcase
            smp.push_back(v);
        end
    endtask

    // Index of the triggering sample, or -1; leaves room for the full post-trigger window.
    function automatic int find_trig(input int pre, input bit edg, input int thr, input int hys);
        bit q = 1'b0;
        for (int j = pre; j < smp.size() - DEPTH; j++) begin
            if (q && (edg ? (smp[j] <= thr) : (smp[j] >= thr)))
                return j;
            if (edg ? (smp[j] >= thr + hys) : (smp[j] <= thr - hys))
                q = 1'b1;
        end
        return -1;
    endfunction

    task automatic capture(input string nm, input int pre, input bit edg, input int thr,
                           input int hys, input int stray_at, input int abort_after);
        int a, s0, n, trig, t_c, d_c, end_c, jj;
        n = smp.size();
        i_pretrig = ADDR_W'(pre);
        i_edge = edg;
        is14_threshold = 14'(thr);
        i14_hysteresis = 14'(hys);
        a  = gcyc;
        s0 = a + 1 + (cur_p - ((a + 1) % (cur_p + 1)));
        trig = find_trig(pre, edg, thr, hys);
        last_trig = trig;
        if (trig >= 0) begin
            t_c   = s0 + trig * (cur_p + 1);
            d_c   = s0 + (trig + DEPTH - 1 - pre) * (cur_p + 1);
            end_c = d_c + 3;
            if (abort_after > 0)
                end_c = t_c + abort_after;
        end else begin
            t_c   = -1;
            d_c   = 1 << 30;
            end_c = s0 + (n - 1) * (cur_p + 1) + 1;
        end
        jj = 0;
        for (int c = a; c < end_c; c++) begin
            i_arm = (c == a) || (stray_at > 0 && c == a + stray_at);
            if (jj < n && c == s0 + jj * (cur_p + 1)) begin
                is14_data = 14'(smp[jj]);
                jj++;
            end else begin
                is14_data = 14'($urandom);
            end
            @(negedge clk);
            if (c > a) begin
                chk({nm, "_trig"}, o_trigger, int'(c == t_c));
                chk({nm, "_busy"}, o_busy, int'(c <= d_c));
                chk({nm, "_done"}, o_done, int'(c > d_c));
            end
            tick();
        end
        i_arm = 1'b0;
        if (trig >= 0 && abort_after == 0) begin
            for (int i = 0; i <= DEPTH; i++) begin
                i_rd_addr = ADDR_W'(i);
                @(negedge clk);
                if (i > 0)
                    chk({nm, "_rd"}, os14_rd_data, smp[trig - pre + i - 1]);
                tick();
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout got=%0d exp=%0d", gcyc, 0);
        $fatal(1, "timeout");
    end

    initial begin
        do_reset(0);

        gen(0, 16 + 300 + DEPTH, -200, 0);
        capture("ramp", 16, 1'b0, 1000, 50, 0, 0);
        rd_chk("ramp_rd16", 16, 1000);
        rd_chk("ramp_rd0", 0, 840);

        // Armed from DONE; stray arm lands in WAIT_TRIG; capture wraps wr_ptr.
        gen(1, 20 + 400 + DEPTH, 300, 0);
        capture("dith", 20, 1'b0, 1000, 50, 30, 0);
        rd_chk("dith_rd20", 20, 1010);
        rd_chk("dith_rd19", 19, 940);

        do_reset(3);
        gen(2, 64 + 200 + DEPTH, 0, 0);
        capture("sine", 64, 1'b1, 0, 100, 0, 0);

        gen(0, 300 + DEPTH, -200, 0);
        capture("pre0", 0, 1'b0, 1000, 50, 0, 0);
        rd_chk("pre0_rd0", 0, 1000);

        gen(0, 255 + 300 + DEPTH, -3000, 0);
        capture("pre255", 255, 1'b0, 1000, 50, 0, 0);
        rd_chk("pre255_rd255", 255, 1000);

        do_reset(0);
        gen(0, 16 + 300 + DEPTH, -200, 0);
        capture("abort", 16, 1'b0, 1000, 50, 0, 20);
        do_reset(0);
        idle_chk(20);

        do_reset(int'($urandom_range(2)));
        for (int r = 0; r < 6; r++) begin
            int pre, thr, hys;
            bit edg;
            pre = int'($urandom_range(DEPTH - 1));
            thr = int'($urandom_range(2000)) - 1000;
            hys = int'($urandom_range(300));
            edg = 1'($urandom_range(1));
            gen(3, pre + 300 + DEPTH, 0, thr);
            capture("rand", pre, edg, thr, hys, 0, 0);
            if (last_trig < 0)
                do_reset(cur_p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trigger_capture_v1_0.md
TRIGGER_CAPTURE_V1_0 -- requirements
Module: trigger_capture_v1_0

Interface
REQ-001 The block SHALL provide parameter ADDR_W, default 8: capture buffer address width; buffer depth DEPTH = 2^ADDR_W samples.
REQ-002 The block SHALL provide port clk  input  1  single clock; all logic is clocked on the rising edge.
REQ-003 The block SHALL provide port rstn  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL provide port i32_prescaler  input  32  sample-strobe divider; a sample is taken every i32_prescaler+1 cycles.
REQ-005 The block SHALL provide port is14_data  input  14  signed filtered sample from the upstream moving-average stage.
REQ-006 The block SHALL provide port is14_threshold  input  14  signed trigger level.
REQ-007 The block SHALL provide port i14_hysteresis  input  14  unsigned re-arm margin.
REQ-008 The block SHALL provide port i_edge  input  1  0 = rising-edge trigger, 1 = falling-edge trigger.
REQ-009 The block SHALL provide port i_arm  input  1  single-cycle arm request.
REQ-010 The block SHALL provide port i_pretrig  input  ADDR_W  number of samples to keep before the trigger, latched on arm.
REQ-011 The block SHALL provide port i_rd_addr  input  ADDR_W  chronological read index, where 0 is the oldest stored sample.
REQ-012 The block SHALL provide port os14_rd_data  output  14  signed read data.
REQ-013 The block SHALL provide port o_busy  output  1  high in every state except IDLE and DONE.
REQ-014 The block SHALL provide port o_done  output  1  high in state DONE.
REQ-015 The block SHALL provide port o_trigger  output  1  one-cycle pulse on the strobe at which the trigger fires.

Function
REQ-016 The sample strobe SHALL assert when the 32-bit counter is at or above i32_prescaler; on that cycle the counter SHALL clear, and on every other cycle it SHALL increment; i32_prescaler=0 SHALL give a strobe every cycle.
REQ-017 The FSM SHALL have the states IDLE, PREFILL, WAIT_TRIG, POST and DONE, and SHALL advance only on strobes except where stated.
REQ-018 In IDLE or DONE, i_arm SHALL latch i_pretrig, clear the write pointer and fill count, and enter PREFILL on the next cycle; i_arm SHALL be ignored in every other state.
REQ-019 PREFILL SHALL write is14_data to buffer[wr_ptr] on each strobe, and SHALL enter WAIT_TRIG once i_pretrig samples have been written; i_pretrig=0 SHALL go straight to WAIT_TRIG.
REQ-020 WAIT_TRIG SHALL keep writing circularly with wr_ptr wrapping modulo DEPTH.
REQ-021 The hysteresis compare SHALL use 15-bit signed threshold±hysteresis with no wrap.
REQ-022 For rising edge, the qualifier SHALL set when data <= threshold-hysteresis; for falling edge, it SHALL set when data >= threshold+hysteresis.
REQ-023 The qualifier SHALL clear on arm.
REQ-024 The trigger SHALL fire on a WAIT_TRIG strobe when the qualifier is set and data >= threshold (rising) or data <= threshold (falling).
REQ-025 A sample that crosses the threshold before the qualifier has set SHALL NOT fire the trigger.
REQ-026 On the trigger, the triggering sample SHALL be written and o_trigger SHALL pulse.
REQ-027 On the trigger, start_ptr SHALL be set to (trigger write address - latched pretrig) mod DEPTH.
REQ-028 On the trigger, the FSM SHALL enter POST.
REQ-029 POST SHALL write DEPTH-1-pretrig further samples, then enter DONE; the buffer then holds DEPTH consecutive samples.
REQ-030 DONE SHALL freeze all writes.
REQ-031 Reads SHALL return buffer[(start_ptr + i_rd_addr) mod DEPTH] registered, with 1-cycle latency and valid in any state.
REQ-032 When i_edge changes while WAIT_TRIG, the qualifier SHALL be re-evaluated from the next strobe.

Reset
REQ-033 rstn low SHALL asynchronously force the FSM to IDLE.
REQ-034 rstn low SHALL asynchronously clear the prescaler counter, the pointers, the fill count and the qualifier.
REQ-035 rstn low SHALL asynchronously force o_busy=0, o_done=0, o_trigger=0 and os14_rd_data=0.
REQ-036 Buffer contents SHALL NOT be reset.
REQ-037 Reset asserted mid-capture SHALL abandon the capture, and a new i_arm SHALL be required afterwards.

Structure
REQ-038 The FSM state encodings SHALL live in a shared package.
REQ-039 The buffer SHALL be the sub-module capture_ram_v1_0: simple dual-port, one write port and one registered read port, inferable as block RAM.

Verification
REQ-040 Rising trigger: i32_prescaler=0, threshold=1000, hysteresis=50, pretrig=16, ramp -200..+2000 step 10 -> o_trigger at the first sample >=1000; rd_addr 16 returns 1000; rd_addr 0 returns 840.
REQ-041 Hysteresis: data dithers 990/1010 without dropping below 950 after arm -> no trigger; after one sample at 940, the next 1010 -> trigger.
REQ-042 Falling edge with i32_prescaler=3: strobe every 4 cycles, the sine crosses downward through threshold 0 -> trigger; DONE after exactly DEPTH-1-pretrig further strobes; o_busy low in DONE.
REQ-043 Boundaries: pretrig=0 -> rd_addr 0 returns the trigger sample; pretrig=255 -> rd_addr 255 returns the trigger sample; capture spans a wr_ptr wrap with order preserved.
REQ-044 Reset mid-POST: pull rstn low for 1 cycle -> immediate IDLE with all outputs 0; i_arm pulsed during WAIT_TRIG -> ignored; i_arm in DONE -> new capture.
